// File: rtl/fb_wb_pkg.sv
// Shared types and constants for the frame-buffer Wishbone arbiter.
package fb_wb_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_TOUT = 2'd3
    } arb_state_t;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Defaults: watchdog depth (1..255) and master-0 grants allowed while master 1 waits
    localparam int DEFAULT_TIMEOUT       = 255;
    localparam int DEFAULT_M0_MAX_GRANTS = 4;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags a hung slave.
module wb_watchdog
    import fb_wb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fire
);

    // count holds the number of stalled cycles already completed, so the
    // current stalled cycle is number count+1; fire on the TIMEOUT-th one.
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Stall counter: cleared on ack/err/leaving grant, saturates at 255
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // A clear (ack or err this cycle) always beats the timeout
    assign fire = enable && !clear && (count == LAST);

endmodule

// File: rtl/fb_wb_arbiter.sv
// Two-master Wishbone arbiter for the DDR2 frame-buffer port.
// Master 0 (display reader) has fixed priority; master 1 (frame writer) is
// guaranteed a grant after M0_MAX_GRANTS consecutive master-0 wins while it
// waits. A watchdog turns a slave that never acks into a Wishbone error.
//
// Handshake: a transfer beat completes on every clock edge where the granted
// master has cyc=1 and stb=1 and the slave returns ack=1 (or err=1); the
// master holds address/data stable until then. The grant is held for the
// whole cyc assertion, so bursts and RMW sequences stay atomic.
module fb_wb_arbiter
    import fb_wb_pkg::*;
#(
    parameter int M0_MAX_GRANTS = DEFAULT_M0_MAX_GRANTS,
    parameter int TIMEOUT       = DEFAULT_TIMEOUT,
    parameter int AW            = 32,
    parameter int DW            = 32
) (
    input  logic            wb_clk,
    input  logic            reset,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_stb_i,
    input  logic            m0_cyc_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_stb_i,
    input  logic            m1_cyc_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      arb_state
);

    localparam logic [2:0] STARVE_LIMIT = 3'(M0_MAX_GRANTS);

    arb_state_t cur_state, nxt_state;
    logic [2:0] starve_cnt;
    logic       tout_m1;     // master that owned the bus when the watchdog fired
    logic       tout_pulse;  // high only on the first TOUT cycle
    logic       wd_clear, wd_enable, wd_fire;
    logic       in_grant;

    assign in_grant  = (cur_state == ST_GNT0) || (cur_state == ST_GNT1);
    assign wd_clear  = s_ack_i || s_err_i || !in_grant;
    assign wd_enable = s_stb_o && !s_ack_i;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (wb_clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .fire   (wd_fire)
    );

    // State register
    always_ff @(posedge wb_clk) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state: arbitrate only from IDLE, release on cyc drop, trap hung slaves
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    nxt_state = (starve_cnt >= STARVE_LIMIT) ? ST_GNT1 : ST_GNT0;
                end else if (m0_cyc_i) begin
                    nxt_state = ST_GNT0;
                end else if (m1_cyc_i) begin
                    nxt_state = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    nxt_state = ST_IDLE;
                end else if (wd_fire) begin
                    nxt_state = ST_TOUT;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    nxt_state = ST_IDLE;
                end else if (wd_fire) begin
                    nxt_state = ST_TOUT;
                end
            end
            ST_TOUT: begin
                if (!(tout_m1 ? m1_cyc_i : m0_cyc_i)) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Remember the timed-out master and flag the TOUT entry cycle for the err pulse
    always_ff @(posedge wb_clk) begin
        if (reset) begin
            tout_m1    <= 1'b0;
            tout_pulse <= 1'b0;
        end else begin
            tout_pulse <= (nxt_state == ST_TOUT) && (cur_state != ST_TOUT);
            if ((nxt_state == ST_TOUT) && (cur_state != ST_TOUT)) begin
                tout_m1 <= (cur_state == ST_GNT1);
            end
        end
    end

    // Starvation counter: counts master-0 wins over a waiting master 1, saturating
    always_ff @(posedge wb_clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (cur_state == ST_IDLE) begin
            if ((nxt_state == ST_GNT1) || !m1_cyc_i) begin
                starve_cnt <= '0;
            end else if ((nxt_state == ST_GNT0) && (starve_cnt != 3'd7)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Output mux: slave sees the granted master, responses go to that master only
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        s_cti_o  = CTI_CLASSIC;
        s_bte_o  = 2'b00;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (cur_state)
            ST_GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                gnt_o    = 2'b01;
            end
            ST_GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                gnt_o    = 2'b10;
            end
            ST_TOUT: begin
                // Slave is cut off; late acks are simply not routed anywhere
                m0_err_o = tout_pulse && !tout_m1;
                m1_err_o = tout_pulse && tout_m1;
                gnt_o    = tout_m1 ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign arb_state = cur_state;

endmodule
